// File: rtl/iic_eeprom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | iic_eeprom_pkg : I2C master command codes and page-writer FSM   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package iic_eeprom_pkg;

  localparam logic [3:0] MAIN_CMD_IDLE = 4'd0;
  localparam logic [3:0] COMPLETE_WR   = 4'd1;
  localparam logic [3:0] WR_WNO_STOP   = 4'd2;
  localparam logic [3:0] COMPLETE_RD   = 4'd3;
  localparam logic [3:0] RD_WNO_STOP   = 4'd4;
  localparam logic [3:0] SET_IDLE      = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CHECK        = 3'd1,
    ST_SET_CMD      = 3'd2,
    ST_SET_MEM_ADDR = 3'd3,
    ST_SEND_DATA    = 3'd4,
    ST_WAIT_TWR     = 3'd5,
    ST_FSH          = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/iic_eeprom_wr_page_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | iic_eeprom_wr_page_if : request/stream and I2C master bus       |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface iic_eeprom_wr_page_if;
  logic        enable;
  logic [7:0]  mem_addr;
  logic [3:0]  len;
  logic        data_vld;
  logic [7:0]  data;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_cmd_vld;
  logic        m_cmd_ready;
  logic [3:0]  m_cmd;
  logic [6:0]  m_addr;
  logic [23:0] m_burst_len;
  logic        m_wr_vld;
  logic        m_wr_ready;
  logic [7:0]  m_wr_data;
  logic        m_wr_last;
  logic        m_rd_ready;

  // slave: the page writer itself; master: the requester plus the I2C master
  modport slave (
    input  enable, mem_addr, len, data_vld, data, m_cmd_ready, m_wr_ready,
    output data_ready, busy, done, err, m_cmd_vld, m_cmd, m_addr,
           m_burst_len, m_wr_vld, m_wr_data, m_wr_last, m_rd_ready
  );

  modport master (
    output enable, mem_addr, len, data_vld, data, m_cmd_ready, m_wr_ready,
    input  data_ready, busy, done, err, m_cmd_vld, m_cmd, m_addr,
           m_burst_len, m_wr_vld, m_wr_data, m_wr_last, m_rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/iic_eeprom_wr_page.sv
`default_nettype none
// +----------------------------------------------------------------+
// | iic_eeprom_wr_page : writes up to one EEPROM page over I2C      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module iic_eeprom_wr_page
  import iic_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'b1010_000,
  parameter int         PAGE_BYTES = 8,
  parameter int         TWR_CLKS   = 250000
) (
  input  wire logic           clock,
  input  wire logic           rst,
  iic_eeprom_wr_page_if.slave bus
);

  localparam int TW = (TWR_CLKS > 0) ? $clog2(TWR_CLKS + 1) : 1;

  state_t        r_state, w_next;
  logic [7:0]    r_mem_addr;
  logic [3:0]    r_len;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_twr_cnt;

  logic [8:0]    w_off, w_sum;
  logic          w_reject, w_accept, w_twr_last;

  // page-crossing test works on the in-page offset of the start address
  assign w_off      = {1'b0, r_mem_addr} & 9'(PAGE_BYTES - 1);
  assign w_sum      = w_off + {5'b0, r_len};
  assign w_reject   = (r_len == 4'd0) || ({5'b0, r_len} > 9'(PAGE_BYTES))
                      || (w_sum > 9'(PAGE_BYTES));
  assign w_accept   = (r_state == ST_SEND_DATA) && bus.data_vld && bus.m_wr_ready;
  assign w_twr_last = (TWR_CLKS == 0) || (r_twr_cnt == TW'(TWR_CLKS - 1));

  assign bus.m_addr     = DEV_ADDR;
  assign bus.m_rd_ready = 1'b0;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mem_addr <= 8'd0;
      r_len      <= 4'd0;
      r_cnt      <= 4'd0;
      r_twr_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && bus.enable) begin
        r_mem_addr <= bus.mem_addr;
        r_len      <= bus.len;
      end
      if (r_state != ST_SEND_DATA)
        r_cnt <= 4'd0;
      else if (w_accept)
        r_cnt <= r_cnt + 4'd1;
      if (r_state == ST_WAIT_TWR)
        r_twr_cnt <= r_twr_cnt + TW'(1);
      else
        r_twr_cnt <= '0;
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.busy        = (r_state != ST_IDLE);
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    bus.data_ready  = 1'b0;
    bus.m_cmd_vld   = 1'b0;
    bus.m_cmd       = MAIN_CMD_IDLE;
    bus.m_burst_len = 24'd0;
    bus.m_wr_vld    = 1'b0;
    bus.m_wr_data   = 8'd0;
    bus.m_wr_last   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.enable) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_reject) begin
          bus.err = 1'b1;
          w_next  = ST_IDLE;
        end else begin
          w_next = ST_SET_CMD;
        end
      end
      ST_SET_CMD: begin
        // burst covers the word-address byte plus the payload
        bus.m_cmd_vld   = 1'b1;
        bus.m_cmd       = COMPLETE_WR;
        bus.m_burst_len = 24'(r_len) + 24'd1;
        if (bus.m_cmd_ready) w_next = ST_SET_MEM_ADDR;
      end
      ST_SET_MEM_ADDR: begin
        bus.m_wr_vld  = 1'b1;
        bus.m_wr_data = r_mem_addr;
        if (bus.m_wr_ready) w_next = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        bus.m_wr_vld   = bus.data_vld;
        bus.m_wr_data  = bus.data;
        bus.data_ready = bus.m_wr_ready;
        bus.m_wr_last  = (r_cnt == r_len - 4'd1);
        if (w_accept && (r_cnt + 4'd1 == r_len)) w_next = ST_WAIT_TWR;
      end
      ST_WAIT_TWR: if (w_twr_last) w_next = ST_FSH;
      ST_FSH: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_iic_eeprom_wr_page.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_iic_eeprom_wr_page : table-driven bench for the page writer  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_iic_eeprom_wr_page;

  localparam int         TWR = 4;
  localparam logic [6:0] DEV = 7'h50;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [7:0]  base;
    int          cmd_hold;
    bit          toggle;
    bit          exp_err;
    logic [23:0] exp_blen;
  } vec_t;

  logic clk;
  logic rst;
  iic_eeprom_wr_page_if bus();

  iic_eeprom_wr_page #(.DEV_ADDR(DEV), .PAGE_BYTES(8), .TWR_CLKS(TWR)) dut (
    .clock(clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard state, updated on the falling edge
  logic [8:0]  wr_q[$];
  int          done_cnt, err_cnt, cmd_hs_cnt, cmd_vld_cnt;
  int          cyc, last_hs_cyc, done_cyc;
  logic [23:0] exp_blen;
  bit          prev_wr_stall;
  logic [7:0]  prev_wr_data;
  bit          src_take;

  // stimulus control
  logic [7:0]  src[16];
  int          src_idx, src_n;
  bit          src_en;
  int          cmd_hold, cmd_wait;
  bit          wr_toggle;

  always @(negedge clk) begin
    cyc++;
    if (bus.m_wr_vld && bus.m_wr_ready) begin
      wr_q.push_back({bus.m_wr_last, bus.m_wr_data});
      last_hs_cyc = cyc;
    end
    if (prev_wr_stall && bus.m_wr_vld)
      chk("wr_data_hold", 64'(bus.m_wr_data), 64'(prev_wr_data));
    prev_wr_stall = bus.m_wr_vld && !bus.m_wr_ready;
    prev_wr_data  = bus.m_wr_data;
    if (bus.m_cmd_vld) begin
      cmd_vld_cnt++;
      chk("cmd_code", 64'(bus.m_cmd), 64'd1);
      chk("burst_len", 64'(bus.m_burst_len), 64'(exp_blen));
      if (bus.m_cmd_ready) cmd_hs_cnt++;
    end else begin
      chk("cmd_idle", 64'({bus.m_cmd, bus.m_burst_len}), 64'd0);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.err) err_cnt++;
    if (!bus.busy)
      chk("idle_outputs",
          64'({bus.data_ready, bus.done, bus.err, bus.m_cmd_vld, bus.m_wr_vld,
               bus.m_wr_data, bus.m_wr_last, bus.m_rd_ready, bus.m_addr}),
          64'(DEV));
    src_take = bus.data_vld && bus.data_ready;
  end

  // source and I2C-master responder, driven 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (src_take) src_idx++;
      bus.data_vld = src_en && (src_idx < src_n);
      bus.data     = (src_idx < src_n && src_idx < 16) ? src[src_idx] : 8'h00;
      if (bus.m_cmd_vld) cmd_wait++;
      else cmd_wait = 0;
      bus.m_cmd_ready = bus.m_cmd_vld && (cmd_wait > cmd_hold);
      bus.m_wr_ready  = wr_toggle ? !bus.m_wr_ready : 1'b1;
    end
  end

  task automatic run_req(input vec_t v, input bit poke);
    bit poked = 0;
    @(posedge clk);
    #1;
    wr_q.delete();
    done_cnt = 0; err_cnt = 0; cmd_hs_cnt = 0; cmd_vld_cnt = 0;
    exp_blen  = v.exp_blen;
    cmd_hold  = v.cmd_hold;
    wr_toggle = v.toggle;
    for (int i = 0; i < 16; i++) src[i] = v.base + 8'(i);
    src_idx = 0;
    src_n   = int'(v.len);
    src_en  = 1'b1;
    bus.enable   = 1'b1;
    bus.mem_addr = v.addr;
    bus.len      = v.len;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    chk("busy_rise", 64'(bus.busy), 64'd1);
    chk("err_pulse", 64'(bus.err), 64'(v.exp_err));
    if (v.exp_err) begin
      @(posedge clk);
      #1;
      chk("busy_fall_err", 64'(bus.busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("err_count", 64'(err_cnt), 64'd1);
      chk("no_cmd_on_err", 64'(cmd_vld_cnt), 64'd0);
      chk("no_wr_on_err", 64'(wr_q.size()), 64'd0);
      chk("no_done_on_err", 64'(done_cnt), 64'd0);
    end else begin
      for (int t = 0; t < 300 && done_cnt == 0; t++) begin
        @(posedge clk);
        #1;
        if (poke && !poked && wr_q.size() == int'(v.len) + 1) begin
          bus.enable = 1'b1;
          poked = 1;
        end else begin
          bus.enable = 1'b0;
        end
      end
      bus.enable = 1'b0;
      chk("done_seen", 64'(done_cnt > 0), 64'd1);
      @(posedge clk);
      #1;
      chk("busy_fall_done", 64'(bus.busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("err_none", 64'(err_cnt), 64'd0);
      chk("cmd_handshakes", 64'(cmd_hs_cnt), 64'd1);
      chk("cmd_stall_cycles", 64'(cmd_vld_cnt), 64'(v.cmd_hold + 1));
      chk("wr_count", 64'(wr_q.size()), 64'(int'(v.len) + 1));
      for (int i = 0; i <= int'(v.len) && i < wr_q.size(); i++) begin
        logic [8:0] e;
        e = (i == 0) ? {1'b0, v.addr} : {(i == int'(v.len)), v.base + 8'(i - 1)};
        chk($sformatf("wr_byte%0d", i), 64'(wr_q[i]), 64'(e));
      end
      chk("twr_latency", 64'(done_cyc - last_hs_cyc), 64'(TWR + 1));
    end
    src_en = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h10, 4'd3, 8'hA1, 0, 1'b0, 1'b0, 24'd4};
    vecs[1] = '{8'h06, 4'd3, 8'h00, 0, 1'b0, 1'b1, 24'd0};
    vecs[2] = '{8'h00, 4'd0, 8'h00, 0, 1'b0, 1'b1, 24'd0};
    vecs[3] = '{8'h00, 4'd9, 8'h00, 0, 1'b0, 1'b1, 24'd0};
    vecs[4] = '{8'h0F, 4'd2, 8'h00, 0, 1'b0, 1'b1, 24'd0};
    vecs[5] = '{8'h00, 4'd8, 8'hB0, 0, 1'b0, 1'b0, 24'd9};
    vecs[6] = '{8'h07, 4'd1, 8'hC5, 0, 1'b0, 1'b0, 24'd2};
    vecs[7] = '{8'h25, 4'd3, 8'hD0, 5, 1'b1, 1'b0, 24'd4};
    vecs[8] = '{8'h1D, 4'd4, 8'h00, 0, 1'b0, 1'b1, 24'd0};

    rst = 1'b1;
    bus.enable = 1'b0; bus.mem_addr = 8'h00; bus.len = 4'd0;
    bus.data_vld = 1'b0; bus.data = 8'h00;
    bus.m_cmd_ready = 1'b0; bus.m_wr_ready = 1'b0;
    src_en = 1'b0; src_idx = 0; src_n = 0; cmd_hold = 0; wr_toggle = 1'b0;
    exp_blen = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({bus.busy, bus.data_ready, bus.done, bus.err, bus.m_cmd_vld, bus.m_cmd,
             bus.m_burst_len, bus.m_wr_vld, bus.m_wr_data, bus.m_wr_last, bus.m_rd_ready,
             bus.m_addr}),
        64'(DEV));
    rst = 1'b0;

    for (int k = 0; k < 9; k++) run_req(vecs[k], 1'b0);

    // reset mid-transfer: source supplies 1 of 3 bytes, then stalls
    @(posedge clk);
    #1;
    wr_q.delete();
    done_cnt = 0; err_cnt = 0;
    exp_blen = 24'd4; cmd_hold = 0; wr_toggle = 1'b0;
    src[0] = 8'h70; src_idx = 0; src_n = 1; src_en = 1'b1;
    bus.enable = 1'b1; bus.mem_addr = 8'h20; bus.len = 4'd3;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    for (int t = 0; t < 50 && wr_q.size() < 2; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_wr_count", 64'(wr_q.size()), 64'd2);
    chk("stall_busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        64'({bus.busy, bus.data_ready, bus.done, bus.err, bus.m_cmd_vld, bus.m_cmd,
             bus.m_burst_len, bus.m_wr_vld, bus.m_wr_data, bus.m_wr_last, bus.m_rd_ready,
             bus.m_addr}),
        64'(DEV));
    src_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(done_cnt), 64'd0);
    chk("no_err_after_reset", 64'(err_cnt), 64'd0);

    run_req(vecs[0], 1'b0);
    // enable pulsed while waiting out the write cycle must be ignored
    run_req(vecs[6], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iic_eeprom_wr_page.md
IIC_EEPROM_WR_PAGE -- requirements
Module: iic_eeprom_wr_page

Interface
REQ-001 SHALL have a single clock domain and asynchronous, active-high reset.
REQ-002 Parameter: DEV_ADDR, 7'b1010_000, 7-bit I2C slave address driven on m_addr.
REQ-003 Parameter: PAGE_BYTES, 8, EEPROM page size in bytes (power of 2).
REQ-004 Parameter: TWR_CLKS, 250000, write-cycle wait in clock cycles after the STOP.
REQ-005 Ports:
- clock  in  1  sole clock.
- rst  in  1  async active-high reset.
- enable  in  1  start request, sampled in IDLE only.
- mem_addr  in  8  EEPROM word address of the first byte.
- len  in  4  byte count.
- data_vld  in  1  source stream valid.
- data  in  8  source byte.
- data_ready  out  1  source accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse on request rejection.
- m_cmd_vld / m_cmd_ready  out/in  1  master command handshake.
- m_cmd  out  4  master command code.
- m_addr  out  7  slave address (constant DEV_ADDR).
- m_burst_len  out  24  bytes in the transfer.
- m_wr_vld / m_wr_ready  out/in  1  master write-data handshake.
- m_wr_data  out  8  master write byte.
- m_wr_last  out  1  marks the final write byte.
- m_rd_ready  out  1  tied 0 (block never reads).

Function
REQ-006 State machine SHALL be IDLE -> CHECK -> SET_CMD -> SET_MEM_ADDR -> SEND_DATA -> WAIT_TWR -> FSH -> IDLE.
REQ-007 IDLE SHALL capture mem_addr and len into registers when enable=1 and go to CHECK; enable in any other state SHALL be ignored.
REQ-008 CHECK SHALL reject the request if len==0, len>PAGE_BYTES, or (mem_addr mod PAGE_BYTES)+len>PAGE_BYTES. On rejection it SHALL pulse err for one cycle, return to IDLE and issue no command; otherwise it SHALL go to SET_CMD.
REQ-009 SET_CMD SHALL hold m_cmd_vld=1, m_cmd=COMPLETE_WR(4'd1) and m_burst_len=len+1 (zero-extended to 24 bits) until the cycle in which m_cmd_vld and m_cmd_ready are both 1, then go to SET_MEM_ADDR.
REQ-010 SET_MEM_ADDR SHALL hold m_wr_vld=1, m_wr_data=captured mem_addr and m_wr_last=0 until m_wr_ready=1, then go to SEND_DATA.
REQ-011 In SEND_DATA, m_wr_vld SHALL equal data_vld, m_wr_data SHALL equal data, and data_ready SHALL equal m_wr_ready (combinational pass-through). data_ready SHALL be 0 in all other states.
REQ-012 SEND_DATA SHALL count accepted bytes (data_vld & m_wr_ready) with a 4-bit counter. m_wr_last SHALL be 1 when count==len-1. SEND_DATA SHALL exit to WAIT_TWR on the acceptance that makes count==len.
REQ-013 WAIT_TWR SHALL count TWR_CLKS cycles using a counter of width $clog2(TWR_CLKS+1), then go to FSH. If TWR_CLKS==0, it SHALL spend exactly one cycle in WAIT_TWR.
REQ-014 FSH SHALL pulse done for one cycle and go to IDLE; busy SHALL fall in the following cycle.
REQ-015 Outside SET_CMD, m_cmd SHALL be MAIN_CMD_IDLE(4'd0), m_cmd_vld=0 and m_burst_len=0. Outside SET_MEM_ADDR/SEND_DATA, m_wr_vld=0, m_wr_data=0 and m_wr_last=0.
REQ-016 A stalled source (data_vld=0) SHALL hold the block in SEND_DATA indefinitely with no timeout.

Reset
REQ-017 rst=1 SHALL asynchronously force state IDLE, clear all counters, and set every output to 0 except m_addr (=DEV_ADDR).
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer and produce no done or err pulse.

Structure
REQ-019 Package iic_eeprom_pkg SHALL hold the master command codes (MAIN_CMD_IDLE=0, COMPLETE_WR=1, WR_WNO_STOP=2, COMPLETE_RD=3, RD_WNO_STOP=4, SET_IDLE=5) and the state enum.
REQ-020 There SHALL be no sub-module; the TWR timer and byte counter are inline.

Verification
REQ-021 mem_addr=8'h10, len=3, data 8'hA1/A2/A3, master always ready -> cmd=1 with burst_len=4; write bytes 10,A1,A2,A3 with m_wr_last only on A3; done pulses TWR_CLKS+1 cycles after the A3 handshake.
REQ-022 mem_addr=8'h06, len=3 -> err pulses once; m_cmd_vld never rises; busy falls 2 cycles after enable.
REQ-023 len=0, and separately len=9 -> err pulses for each; no master activity.
REQ-024 m_cmd_ready held low 5 cycles, then m_wr_ready toggling 1/0 -> m_cmd, m_burst_len and m_wr_data stay stable while stalled; byte order is preserved.
REQ-025 rst pulsed during SEND_DATA after 1 of 3 bytes -> all outputs 0 asynchronously; no done pulse; a subsequent request completes normally.
REQ-026 enable pulsed during WAIT_TWR -> ignored; exactly one done pulse.
